// File: rtl/branch_unit.sv
// Two-stage branch/jump resolution unit.
// S1 decodes the instruction class and immediate and registers the operands;
// S2 evaluates the condition, forms target/link and registers the result.
// A saturating counter tracks retired, correctly aligned, taken control transfers.
module branch_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16,
  parameter int C_EXT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic             out_misaligned,
  output logic             out_illegal,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {OP_BR, OP_JAL, OP_JALR, OP_ILL} op_e;

  // S1 state
  logic            r_s1_valid;
  op_e             r_s1_op;
  logic [2:0]      r_s1_f3;
  logic [XLEN-1:0] r_s1_imm;
  logic [XLEN-1:0] r_s1_pc;
  logic [XLEN-1:0] r_s1_rs1;
  logic [XLEN-1:0] r_s1_rs2;

  // S2 (output) state
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_pc;
  logic             r_out_taken;
  logic [XLEN-1:0]  r_out_target;
  logic [XLEN-1:0]  r_out_link;
  logic             r_out_misaligned;
  logic             r_out_illegal;
  logic [CNT_W-1:0] r_taken_count;

  logic            w_s2_adv;
  logic            w_accept;
  op_e             w_dec_op;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_cond;
  logic [XLEN-1:0] w_pc_sum;
  logic [XLEN-1:0] w_reg_sum;
  logic            w_taken;
  logic            w_illegal;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_count_en;

  // S2 can take new data when it is empty or its result is being consumed;
  // S1 is free when empty or draining into S2 this cycle.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready && !flush;

  // Decode instruction class and sign-extended immediate
  always_comb begin
    w_dec_op  = OP_ILL;
    w_dec_imm = '0;
    case (in_instr[6:0])
      7'b1100011: begin
        w_dec_op  = OP_BR;
        w_dec_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        w_dec_op  = OP_JAL;
        w_dec_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111: begin
        w_dec_op  = (in_instr[14:12] == 3'b000) ? OP_JALR : OP_ILL;
        w_dec_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      end
      default: begin
        w_dec_op  = OP_ILL;
        w_dec_imm = '0;
      end
    endcase
  end

  // S1 register: capture decoded fields and operands on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ILL;
      r_s1_f3    <= '0;
      r_s1_imm   <= '0;
      r_s1_pc    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_op  <= w_dec_op;
        r_s1_f3  <= in_instr[14:12];
        r_s1_imm <= w_dec_imm;
        r_s1_pc  <= in_pc;
        r_s1_rs1 <= in_rs1_val;
        r_s1_rs2 <= in_rs2_val;
      end
    end
  end

  assign w_eq      = (r_s1_rs1 == r_s1_rs2);
  assign w_lt_s    = ($signed(r_s1_rs1) < $signed(r_s1_rs2));
  assign w_lt_u    = (r_s1_rs1 < r_s1_rs2);
  assign w_pc_sum  = r_s1_pc + r_s1_imm;
  assign w_reg_sum = r_s1_rs1 + r_s1_imm;

  // Branch condition select by funct3; reserved encodings never take
  always_comb begin
    w_cond = 1'b0;
    case (r_s1_f3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = !w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = !w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = !w_lt_u;
      default: w_cond = 1'b0;
    endcase
  end

  // Resolve taken/illegal/target for the instruction sitting in S1
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    w_target  = w_pc_sum;
    case (r_s1_op)
      OP_BR: begin
        w_taken   = w_cond;
        w_illegal = (r_s1_f3[2:1] == 2'b01);
      end
      OP_JAL: begin
        w_taken = 1'b1;
      end
      OP_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_reg_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // With 4-byte alignment only, a taken target with bit 1 set faults
  assign w_misaligned = (C_EXT == 0) && w_taken && w_target[1];

  // S2 register: outputs hold while stalled, flush drops the valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid      <= 1'b0;
      r_out_pc         <= '0;
      r_out_taken      <= 1'b0;
      r_out_target     <= '0;
      r_out_link       <= '0;
      r_out_misaligned <= 1'b0;
      r_out_illegal    <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_s2_adv && r_s1_valid && !flush) begin
        r_out_pc         <= r_s1_pc;
        r_out_taken      <= w_taken;
        r_out_target     <= w_target;
        r_out_link       <= r_s1_pc + XLEN'(4);
        r_out_misaligned <= w_misaligned;
        r_out_illegal    <= w_illegal;
      end
    end
  end

  assign w_count_en = r_out_valid && out_ready && r_out_taken &&
                      !r_out_misaligned && !r_out_illegal &&
                      (r_taken_count != {CNT_W{1'b1}});

  // Saturating retire counter; a handshake in a flush cycle still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_count <= '0;
    end else if (w_count_en) begin
      r_taken_count <= r_taken_count + CNT_W'(1);
    end
  end

  assign out_valid      = r_out_valid;
  assign out_pc         = r_out_pc;
  assign out_taken      = r_out_taken;
  assign out_target     = r_out_target;
  assign out_link       = r_out_link;
  assign out_misaligned = r_out_misaligned;
  assign out_illegal    = r_out_illegal;
  assign taken_count    = r_taken_count;

endmodule
